// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared opcodes, FSM encoding and byte-enable constants
// Purpose: common definitions for the M-stage data-memory bus controller.
// Ports: none (package).
package cpu_defs;

  // Load opcodes (instr[31:26])
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  // Store opcodes
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  // Byte-enable patterns
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } bus_state_t;

  // How the returned word is narrowed/extended
  typedef enum logic [2:0] {
    LK_W  = 3'd0,
    LK_H  = 3'd1,
    LK_HU = 3'd2,
    LK_B  = 3'd3,
    LK_BU = 3'd4
  } ld_kind_t;

endpackage

// File: rtl/mem_data_ext.sv
// rtl/mem_data_ext.sv - load data lane select and sign/zero extension
// Purpose: turn the raw bus read word into the architectural load result.
// Ports:
//   rdata   in  32  raw read word from the bus
//   addr_lo in  2   byte offset of the access
//   kind    in  3   load kind (ld_kind_t encoding)
//   data    out 32  extended load result
module mem_data_ext
  import cpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  kind,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(rdata >> {addr_lo, 3'b000});
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (kind)
      LK_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LK_BU:   data = {24'h0, byte_sel};
      LK_H:    data = {{16{half_sel[15]}}, half_sel};
      LK_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_bus_ctrl.sv
// rtl/mem_stage_bus_ctrl.sv - M-stage data-memory bus controller with stall
// Purpose: decode the M-stage load/store, run a req/ready access on the DM bus,
// stall the pipeline until it completes, and return the extended load data.
// Ports:
//   clk, reset (async, active-low)
//   M_instr/M_ALUres/M_RD2  in  M-stage instruction, byte address, store data
//   pipe_adv                in  M stage advances at this edge
//   bus_req/bus_we/bus_addr/bus_byteen/bus_wdata  out  registered bus request
//   bus_ready/bus_rdata     in  responder completion and read word
//   mem_stall               out freeze the upstream pipeline
//   M_memdata/bus_err       out load result / timeout abort, valid in HOLD
//   exc_adel/exc_ades       out misaligned load/store (combinational)
module mem_stage_bus_ctrl
  import cpu_defs::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_instr,
  input  logic [31:0] M_ALUres,
  input  logic [31:0] M_RD2,
  input  logic        pipe_adv,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic [31:0] M_memdata,
  output logic        bus_err,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  bus_state_t       state;
  logic [CNT_W-1:0] cnt;
  ld_kind_t         ld_kind, ld_kind_q;
  logic [1:0]       addr_lo_q;
  logic             is_load, is_store, is_word, is_half, misalign, mem_go;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata, ext_data;
  logic [5:0]       opcode;
  logic             unused_instr;

  assign opcode       = M_instr[31:26];
  assign unused_instr = ^M_instr[25:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_word  = 1'b0;
    is_half  = 1'b0;
    ld_kind  = LK_W;
    case (opcode)
      OP_LW:   begin is_load = 1'b1;  is_word = 1'b1; ld_kind = LK_W;  end
      OP_LH:   begin is_load = 1'b1;  is_half = 1'b1; ld_kind = LK_H;  end
      OP_LHU:  begin is_load = 1'b1;  is_half = 1'b1; ld_kind = LK_HU; end
      OP_LB:   begin is_load = 1'b1;  ld_kind = LK_B;  end
      OP_LBU:  begin is_load = 1'b1;  ld_kind = LK_BU; end
      OP_SW:   begin is_store = 1'b1; is_word = 1'b1; end
      OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
      OP_SB:   begin is_store = 1'b1; end
      default: ;
    endcase
  end

  assign misalign = (is_word & (|M_ALUres[1:0])) | (is_half & M_ALUres[0]);
  assign exc_adel = is_load & misalign;
  assign exc_ades = is_store & misalign;
  assign mem_go   = (is_load | is_store) & ~misalign;

  // Sub-word stores replicate the data across all lanes; byteen picks the lane.
  always_comb begin
    st_be    = BE_WORD;
    st_wdata = M_RD2;
    case (opcode)
      OP_SH: begin
        st_be    = M_ALUres[1] ? BE_HI_HALF : BE_LO_HALF;
        st_wdata = {2{M_RD2[15:0]}};
      end
      OP_SB: begin
        st_be    = BE_BYTE0 << M_ALUres[1:0];
        st_wdata = {4{M_RD2[7:0]}};
      end
      default: ;
    endcase
  end

  // Stall in IDLE comes straight from decode so the access costs no extra cycle.
  assign mem_stall = ((state == ST_IDLE) & mem_go) | (state == ST_WAIT);

  mem_data_ext u_ext (
    .rdata   (bus_rdata),
    .addr_lo (addr_lo_q),
    .kind    (ld_kind_q),
    .data    (ext_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_byteen <= '0;
      bus_wdata  <= '0;
      M_memdata  <= '0;
      bus_err    <= 1'b0;
      ld_kind_q  <= LK_W;
      addr_lo_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_go) begin
            bus_req    <= 1'b1;
            bus_we     <= is_store;
            bus_addr   <= {M_ALUres[31:2], 2'b00};
            bus_byteen <= st_be;
            bus_wdata  <= st_wdata;
            ld_kind_q  <= ld_kind;
            addr_lo_q  <= M_ALUres[1:0];
            cnt        <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus_ready) begin
            M_memdata <= ext_data;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            state     <= ST_HOLD;
          end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
            M_memdata <= '0;
            bus_err   <= 1'b1;
            bus_req   <= 1'b0;
            state     <= ST_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          // Without pipe_adv the same instruction is still in M; do not re-issue.
          if (pipe_adv) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_bus_ctrl.sv
// tb/tb_mem_stage_bus_ctrl.sv - self-checking bench for mem_stage_bus_ctrl
module tb_mem_stage_bus_ctrl;

  localparam int TO = 4;

  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
  localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_instr, M_ALUres, M_RD2;
  logic        pipe_adv;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        mem_stall;
  logic [31:0] M_memdata;
  logic        bus_err, exc_adel, exc_ades;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage_bus_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .M_instr    (M_instr),
    .M_ALUres   (M_ALUres),
    .M_RD2      (M_RD2),
    .pipe_adv   (pipe_adv),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_byteen (bus_byteen),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .mem_stall  (mem_stall),
    .M_memdata  (M_memdata),
    .bus_err    (bus_err),
    .exc_adel   (exc_adel),
    .exc_ades   (exc_ades)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_is_load(input logic [5:0] op);
    return op == LW || op == LH || op == LHU || op == LB || op == LBU;
  endfunction

  function automatic bit m_is_store(input logic [5:0] op);
    return op == SW || op == SH || op == SB;
  endfunction

  function automatic bit m_misaligned(input logic [5:0] op, input logic [31:0] a);
    if (op == LW || op == SW) return (a % 4) != 0;
    if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
    if (op == SH) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
    if (op == SB) return 4'(1 << (a % 4));
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] d);
    if (op == SH) return (d & 32'hFFFF) * 32'h0001_0001;
    if (op == SB) return (d & 32'hFF) * 32'h0101_0101;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    if (op == LB || op == LBU) begin
      v = (w / (32'd1 << (8 * (a % 4)))) % 256;
      if (op == LB && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (op == LH || op == LHU) begin
      v = (w / (32'd1 << (16 * ((a % 4) / 2)))) % 65536;
      if (op == LH && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return w;
  endfunction

  // Full access: issue in IDLE, respond in WAIT cycle d (0-based), hold, then advance.
  // Entered shortly after a posedge with the FSM in IDLE.
  task automatic run_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd2,
                            input logic [31:0] rdata, input int d, input int hold_n);
    int  stall_n = 0;
    int  w = 0;
    bit  done = 0;
    bit  timed_out = (d >= TO);
    logic [31:0] exp_md = timed_out ? 32'h0 : m_load(op, a, rdata);
    M_instr  = {op, 26'($urandom)};
    M_ALUres = a;
    M_RD2    = rd2;
    pipe_adv = 1'b0;
    bus_ready = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mem_stall) begin
        stall_n++;
        if (bus_req) begin
          check_eq("wait_addr", bus_addr, a & 32'hFFFF_FFFC);
          check_eq("wait_we", 32'(bus_we), 32'(m_is_store(op)));
          check_eq("wait_be", 32'(bus_byteen), 32'(m_be(op, a)));
          if (m_is_store(op)) check_eq("wait_wdata", bus_wdata, m_wdata(op, rd2));
          bus_ready = (w == d);
          bus_rdata = (w == d) ? rdata : $urandom;
          w++;
        end else begin
          check_eq("idle_no_req", 32'(bus_req), 32'd0);
          bus_ready = 1'($urandom);
          bus_rdata = $urandom;
        end
        @(posedge clk);
        #1;
        bus_ready = 1'b0;
      end else begin
        done = 1;
      end
    end
    check_eq("access_done", 32'(done), 32'd1);
    check_eq("stall_cycles", stall_n, 1 + (timed_out ? TO : d + 1));
    check_eq("hold_req", 32'(bus_req), 32'd0);
    check_eq("hold_err", 32'(bus_err), 32'(timed_out));
    if (m_is_load(op) || timed_out) check_eq("hold_memdata", M_memdata, exp_md);
    for (int h = 0; h < hold_n; h++) begin
      bus_ready = 1'($urandom);
      @(negedge clk);
      check_eq("hold_noreissue", {30'd0, bus_req, mem_stall}, 32'd0);
      check_eq("hold_err_keep", 32'(bus_err), 32'(timed_out));
      if (m_is_load(op) || timed_out) check_eq("hold_md_keep", M_memdata, exp_md);
    end
    bus_ready = 1'b0;
    pipe_adv  = 1'b1;
    @(posedge clk);
    #1;
    pipe_adv = 1'b0;
    M_instr  = 32'h0;
  endtask

  task automatic run_misaligned(input logic [5:0] op, input logic [31:0] a);
    M_instr  = {op, 26'($urandom)};
    M_ALUres = a;
    M_RD2    = $urandom;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("mis_adel", 32'(exc_adel), 32'(m_is_load(op)));
      check_eq("mis_ades", 32'(exc_ades), 32'(m_is_store(op)));
      check_eq("mis_stall_req", {30'd0, mem_stall, bus_req}, 32'd0);
      @(posedge clk);
      #1;
    end
    M_instr = 32'h0;
  endtask

  task automatic reset_mid_wait();
    M_instr  = {LW, 26'h0};
    M_ALUres = 32'h0000_0040;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_pre_req", 32'(bus_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_req_drop", 32'(bus_req), 32'd0);
    check_eq("rst_addr_clr", bus_addr, 32'h0);
    M_instr   = 32'h0;
    bus_ready = 1'b1;
    bus_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("post_rst_ready_ignored", {30'd0, bus_req, mem_stall}, 32'd0);
      check_eq("post_rst_memdata", M_memdata, 32'h0);
    end
    bus_ready = 1'b0;
    @(posedge clk);
    #1;
    run_access(LW, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 1, 0);
  endtask

  logic [5:0] op_tab [8];

  initial begin
    op_tab = '{LW, LH, LHU, LB, LBU, SW, SH, SB};
    reset = 1'b0;
    M_instr = 32'h0; M_ALUres = 32'h0; M_RD2 = 32'h0;
    pipe_adv = 1'b0; bus_ready = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(bus_req), 32'd0);
    check_eq("rst_stall", 32'(mem_stall), 32'd0);
    check_eq("rst_memdata", M_memdata, 32'h0);
    check_eq("rst_err", 32'(bus_err), 32'd0);
    check_eq("rst_be", 32'(bus_byteen), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_access(LW,  32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1);
    run_access(SB,  32'h0000_0203, 32'h0000_00A5, 32'h0, 2, 0);
    run_access(LB,  32'h0000_0012, 32'h0, 32'h0080_F000, 0, 0);
    run_access(LBU, 32'h0000_0012, 32'h0, 32'h0080_F000, 1, 0);
    run_access(LH,  32'h0000_0012, 32'h0, 32'h8001_0000, 0, 0);
    run_misaligned(LW, 32'h0000_0102);
    run_misaligned(SH, 32'h0000_0101);
    run_access(LW,  32'h0000_0300, 32'h0, 32'h0, 99, 3);
    reset_mid_wait();

    for (int i = 0; i < 60; i++) begin
      logic [5:0]  op;
      logic [31:0] a;
      op = op_tab[$urandom_range(0, 7)];
      a  = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (op == LW || op == SW) a = a & 32'hFFFF_FFFC;
        else if (op == LH || op == LHU || op == SH) a = a & 32'hFFFF_FFFE;
      end
      if (m_misaligned(op, a)) run_misaligned(op, a);
      else run_access(op, a, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_bus_ctrl.md
Name: mem_stage_bus_ctrl

Overview:
- Consumer side of the E->M pipeline register.
- Takes the M-stage instruction, address (ALU result) and store data, and runs a req/ready transaction on the data-memory bus.
- Produces byte enables, replicated store data and sign/zero-extended load data.
- Asserts a stall that freezes the pipeline until the access completes. It sits between the M-stage register outputs and the external DM bus.

Parameters:
TIMEOUT, 255, max cycles waiting in WAIT before aborting with bus_err; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
M_instr  in  32  instruction in M stage; opcode is [31:26].
M_ALUres  in  32  effective byte address.
M_RD2  in  32  store source data.
pipe_adv  in  1  M stage advances to W at this edge (external enable, includes other hazards).
bus_req  out  1  request valid.
bus_we  out  1  1 = store, 0 = load.
bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
bus_byteen  out  4  byte enables.
bus_wdata  out  32  replicated store data.
bus_ready  in  1  responder completes the access this cycle.
bus_rdata  in  32  read word, valid when bus_ready.
mem_stall  out  1  freeze PC/FD/DE/EM and bubble into MW.
M_memdata  out  32  extended load result.
bus_err  out  1  access aborted by timeout; valid in HOLD.
exc_adel  out  1  misaligned load (combinational).
exc_ades  out  1  misaligned store (combinational).

Behaviour:
- Decode (combinational):
  - Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - Stores: sw 101011, sh 101001, sb 101000.
  - mem_op = load|store. All other opcodes, including nop 0x00000000, are ignored.
- Alignment:
  - Word ops misaligned if addr[1:0]!=0; half ops misaligned if addr[0]!=0.
  - A misaligned op asserts exc_adel/exc_ades, issues no bus access and no stall. The FSM stays IDLE.
- Store formatting:
  - sw: be=1111, wdata=RD2.
  - sh: be=0011 (addr[1]=0) or 1100, wdata={2{RD2[15:0]}}.
  - sb: be=0001<<addr[1:0], wdata={4{RD2[7:0]}}.
  - Loads: be=1111.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: on an aligned mem_op, mem_stall=1 combinationally; at the edge, register bus_addr/bus_we/bus_byteen/bus_wdata plus the load kind and addr[1:0], clear the counter, go WAIT.
  - WAIT: bus_req=1, mem_stall=1, bus outputs held stable. If bus_ready, capture the extended rdata into M_memdata, clear bus_err, go HOLD. Otherwise, if TIMEOUT!=0 and count==TIMEOUT-1, set bus_err=1 and M_memdata=0, go HOLD; else count++.
  - HOLD: bus_req=0, mem_stall=0, M_memdata/bus_err held. pipe_adv=1 -> IDLE; pipe_adv=0 -> stay (same instruction, no re-issue).
- Load extension:
  - lb/lbu select byte addr[1:0]; lh/lhu select half addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Latency: minimum 3 cycles per access (IDLE, WAIT with ready, HOLD); each extra WAIT cycle adds 1.
- Registered outputs: bus_req, bus_we, bus_addr, bus_byteen, bus_wdata, M_memdata and bus_err are registers.
- Reset (async, reset==0): state=IDLE, counter=0, and all registered outputs=0. mem_stall then follows IDLE decode.
  - Reset mid-WAIT drops bus_req immediately.
  - A response arriving after reset is ignored.
- bus_ready outside WAIT is ignored.
- The pipeline must hold M_instr stable while mem_stall=1.

Decomposition:
- Shared package cpu_defs: opcode constants (OP_LW…OP_SB), FSM state encoding, byte-enable constants.
- Sub-module mem_data_ext: combinational load extension (rdata, addr[1:0], load kind -> 32-bit).
- Store formatting and the FSM stay in the top module.

Test Plan:
- lw addr 0x100, ready in the 1st WAIT cycle, rdata 0xDEADBEEF -> bus_addr=0x100, be=1111, we=0; stall high 2 cycles; HOLD M_memdata=0xDEADBEEF.
- sb addr 0x203, RD2=0x000000A5, ready after 3 WAIT cycles -> be=1000, wdata=0xA5A5A5A5, we=1; stall high 4 cycles; bus outputs stable throughout WAIT.
- lb/lbu addr 0x12, rdata 0x0080F000 -> lb gives 0xFFFFFF80, lbu gives 0x00000080; lh addr 0x12, rdata 0x8001_0000 -> 0xFFFF8001.
- lw addr 0x102 -> exc_adel=1, bus_req never asserted, mem_stall=0. sh addr 0x101 -> exc_ades=1.
- TIMEOUT=4, bus_ready never asserted -> HOLD after 4 WAIT cycles, bus_err=1, M_memdata=0. HOLD with pipe_adv=0 for 3 cycles -> no re-issue.
- reset pulled low during WAIT -> bus_req=0 at once, state IDLE. A later bus_ready=1 has no effect; after release, an aligned lw re-issues cleanly.
